mult_datapath: RTL and testbench
================================

# mult_datapath

Datapath for the 16x9 unsigned sequential shift-add multiplier. It sits directly downstream of the control table and sequencer and consumes their per-state strobes (`load_Mx`, `load_My`, `shift_My`, `clr_Acc`, `load_Acc`, `shift_in`). It holds the multiplicand, the multiplier shift register, the accumulator and an iteration counter. It returns `My0` and `cnt_zero` to the controller and presents the 25-bit product.

## Interface
- `WX`, 16: multiplicand width. Fixed for this design; the port widths below use it.
- `WY`, 9: multiplier width. Fixed for this design; the port widths below use it.
- `CLK` input 1: single clock, rising edge.
- `RESET` input 1: reset, asynchronous, active-low.
- `X_in` input 16: multiplicand data.
- `Y_in` input 9: multiplier data.
- `load_Mx` input 1: load `X_in` into Mx.
- `load_My` input 1: load `Y_in` into My and reload the counter.
- `shift_My` input 1: shift My right by one and decrement the counter.
- `clr_Acc` input 1: clear the accumulator.
- `load_Acc` input 1: conditional add into the accumulator.
- `shift_in` input 1: shift the accumulator right by one.
- `My0` output 1: My[0]. Multiplier bit for the current iteration.
- `cnt_zero` output 1: iteration counter equals 0.
- `product` output 25: {Acc[15:0], My[8:0]}.
- `product_valid` output 1: high when the product is complete.

## Operation
- Registers:
  - Mx[15:0]
  - My[8:0]
  - Acc[16:0] (bit 16 is the carry)
  - cnt[3:0]
  - valid
- Async reset (`RESET`=0) clears all registers to 0.
  - Outputs during reset: `product`=0, `My0`=0, `product_valid`=0.
  - `cnt_zero`=1, because cnt=0.
- Mx: when `load_Mx`=1, Mx <= `X_in`. Otherwise it holds.
- Acc, priority `clr_Acc` > `load_Acc` > `shift_in`:
  - `clr_Acc`: Acc <= 0.
  - `load_Acc`: Acc <= {1'b0, Acc[15:0]} + (My[0] ? Mx : 0). Full 17-bit sum.
  - `shift_in`: Acc <= {1'b0, Acc[16:1]}.
- My, priority `load_My` > `shift_My`:
  - `load_My`: My <= `Y_in`.
  - `shift_My`: My <= {Acc[0], My[8:1]}. Acc[0] is the pre-edge value, so it is correct when `shift_in` is asserted in the same cycle.
- cnt:
  - `load_My` or `clr_Acc`: cnt <= 9.
  - `shift_My` with cnt != 0: cnt <= cnt - 1.
  - `shift_My` with cnt = 0: cnt holds at 0. No wrap-around.
- valid:
  - Set on the edge where cnt goes 1 -> 0 through `shift_My`.
  - Cleared by `load_My` or `clr_Acc`. Clearing has priority over setting.
  - Holds otherwise, including during further `load_Acc`/`shift_in` activity.
- One iteration:
  1. `load_Acc` cycle.
  2. Cycle with `shift_in`=`shift_My`=1.
- After 9 iterations, Acc[16]=0 and `product` = Mx*Y. Maximum value is 0x1FEFE01, which fits in 25 bits.
- `load_Mx` is independent of the Acc and My controls and may coincide with any of them.

## Timing
- All state updates happen on the rising `CLK` edge. Strobes are sampled at that edge.
- Outputs are register-driven or combinational from registers, with no input-to-output combinational path. Each output reflects the edge that caused it.
- Latency:
  - Load cycle: 1 cycle with `load_Mx`, `load_My`, `clr_Acc` together.
  - Then 9 x (add, shift) = 18 cycles.
  - `product_valid` is high after edge 19 counted from the load edge.
- `My0` and `cnt_zero` update one edge after the strobe that changes them. The controller samples them in the following state.
- Reset mid-operation:
  - Immediate asynchronous clear of every register, including valid.
  - Release is synchronous to `CLK`. The first edge after release obeys the strobes.
- Simultaneous `clr_Acc` + `load_Acc` + `shift_in`: Acc = 0.
- Simultaneous `load_My` + `shift_My`: My = `Y_in`, cnt = 9.

## Test plan
- Reset check: assert `RESET`=0 mid-run at iteration 4 of 0x1234 x 0x0AB. Required on the next sample, with no clock edge needed:
  - `product`=0, `product_valid`=0, `cnt_zero`=1.
- 3 x 5 with the full sequence (load, then 9 add/shift pairs). Required:
  - `product`=25'h000000F and `product_valid`=1 after edge 19.
  - `cnt_zero` goes to 1 on the same edge.
- 16'hFFFF x 9'h1FF. Required:
  - `product`=25'h1FEFE01.
  - The carry is exercised: Acc[16]=1 after an add.
  - Acc[16]=0 at the end.
- 0x1234 x 0x0AB. Required: `product`=25'h00C28BC. Check `My0` after each shift matches bits of 0x0AB, LSB first: 1,1,0,1,0,1,0,1,0.
- Boundary strobes:
  - Extra `shift_My` with cnt=0: cnt stays 0 and valid stays 1.
  - `clr_Acc`+`load_Acc`+`shift_in` together: Acc=0.
  - `load_My`+`shift_My` together: My=`Y_in` and `product_valid` cleared.
- Operands of 0: X=0 or Y=0. Required: `product`=0 and valid set at edge 19. Also run a back-to-back second multiply without reset; it must clear valid on its load edge.

Source files
------------

// File: rtl/mult_datapath.sv
// mult_datapath: 16x9 unsigned shift-add multiplier datapath with iteration counter
module mult_datapath #(
  parameter int WX = 16,
  parameter int WY = 9
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WX-1:0]    X_in,
  input  logic [WY-1:0]    Y_in,
  input  logic             load_Mx,
  input  logic             load_My,
  input  logic             shift_My,
  input  logic             clr_Acc,
  input  logic             load_Acc,
  input  logic             shift_in,
  output logic             My0,
  output logic             cnt_zero,
  output logic [WX+WY-1:0] product,
  output logic             product_valid
);
  logic [WX-1:0] mx_q, mx_d;
  logic [WY-1:0] my_q, my_d;
  logic [WX:0]   acc_q, acc_d, sum;
  logic [3:0]    cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic          restart;

  // next-state: clear beats add beats shift on Acc, load beats shift on My, restart beats completion on valid
  always_comb begin
    restart = load_My | clr_Acc;
    sum     = {1'b0, acc_q[WX-1:0]} + {1'b0, my_q[0] ? mx_q : {WX{1'b0}}};
    mx_d    = load_Mx ? X_in : mx_q;
    acc_d   = clr_Acc ? '0 : load_Acc ? sum : shift_in ? {1'b0, acc_q[WX:1]} : acc_q;
    my_d    = load_My ? Y_in : shift_My ? {acc_q[0], my_q[WY-1:1]} : my_q;
    cnt_d   = restart ? 4'(WY) : (shift_My && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
    valid_d = restart ? 1'b0 : (shift_My && cnt_q == 4'd1) ? 1'b1 : valid_q;
  end

  // state registers, all cleared asynchronously
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      mx_q    <= '0;
      my_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      mx_q    <= mx_d;
      my_q    <= my_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign My0           = my_q[0];
  assign cnt_zero      = (cnt_q == 4'd0);
  assign product       = {acc_q[WX-1:0], my_q};
  assign product_valid = valid_q;
endmodule

// File: tb/tb_mult_datapath.sv
// tb_mult_datapath: directed self-checking bench for mult_datapath
module tb_mult_datapath;
  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [15:0] X_in = '0;
  logic [8:0]  Y_in = '0;
  logic        load_Mx = 1'b0, load_My = 1'b0, shift_My = 1'b0;
  logic        clr_Acc = 1'b0, load_Acc = 1'b0, shift_in = 1'b0;
  logic        My0, cnt_zero, product_valid;
  logic [24:0] product;
  int          checks = 0;
  int          errors = 0;

  mult_datapath dut (
    .CLK(CLK), .RESET(RESET), .X_in(X_in), .Y_in(Y_in),
    .load_Mx(load_Mx), .load_My(load_My), .shift_My(shift_My),
    .clr_Acc(clr_Acc), .load_Acc(load_Acc), .shift_in(shift_in),
    .My0(My0), .cnt_zero(cnt_zero), .product(product), .product_valid(product_valid)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // strobe order {load_Mx, load_My, shift_My, clr_Acc, load_Acc, shift_in}
  task automatic step(input logic [5:0] s);
    {load_Mx, load_My, shift_My, clr_Acc, load_Acc, shift_in} = s;
    @(posedge CLK);
    #1;
    {load_Mx, load_My, shift_My, clr_Acc, load_Acc, shift_in} = '0;
  endtask

  task automatic load(input logic [15:0] x, input logic [8:0] y);
    X_in = x;
    Y_in = y;
    step(6'b110100);
  endtask

  task automatic mul(input string tag, input logic [15:0] x, input logic [8:0] y,
                     input logic [24:0] exp, input bit chk_my0, input bit chk_carry);
    logic [8:0] yv;
    yv = y;
    load(x, y);
    check({tag, "_load_valid"}, 32'(product_valid), 32'd0);
    for (int i = 0; i < 9; i++) begin
      if (chk_my0) check($sformatf("%s_my0_%0d", tag, i), 32'(My0), 32'(yv[i]));
      step(6'b000010);
      if (chk_carry && i == 1) check({tag, "_carry_set"}, 32'(dut.acc_q[16]), 32'd1);
      if (i == 8) begin
        check({tag, "_valid_pre"}, 32'(product_valid), 32'd0);
        check({tag, "_cnt_pre"}, 32'(cnt_zero), 32'd0);
      end
      step(6'b001001);
    end
    check({tag, "_product"}, 32'(product), 32'(exp));
    check({tag, "_valid"}, 32'(product_valid), 32'd1);
    check({tag, "_cnt_zero"}, 32'(cnt_zero), 32'd1);
    if (chk_carry) check({tag, "_carry_end"}, 32'(dut.acc_q[16]), 32'd0);
  endtask

  initial begin
    #12;
    check("rst_product", 32'(product), 32'd0);
    check("rst_valid", 32'(product_valid), 32'd0);
    check("rst_cnt_zero", 32'(cnt_zero), 32'd1);
    check("rst_my0", 32'(My0), 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    #1;

    // mid-run asynchronous reset during iteration 4
    load(16'h1234, 9'h0AB);
    for (int i = 0; i < 3; i++) begin
      step(6'b000010);
      step(6'b001001);
    end
    step(6'b000010);
    check("mid_cnt_busy", 32'(cnt_zero), 32'd0);
    RESET = 1'b0;
    #1;
    check("mid_rst_product", 32'(product), 32'd0);
    check("mid_rst_valid", 32'(product_valid), 32'd0);
    check("mid_rst_cnt_zero", 32'(cnt_zero), 32'd1);
    #1;
    RESET = 1'b1;

    mul("m3x5", 16'd3, 9'd5, 25'h000000F, 1'b0, 1'b0);
    mul("mff", 16'hFFFF, 9'h1FF, 25'h1FEFE01, 1'b0, 1'b1);
    mul("m1234", 16'h1234, 9'h0AB, 25'h00C28BC, 1'b1, 1'b0);

    // extra shift with counter at 0
    step(6'b001000);
    check("xshift_cnt_zero", 32'(cnt_zero), 32'd1);
    check("xshift_valid", 32'(product_valid), 32'd1);

    // clear wins over add and shift
    step(6'b000111);
    check("clr_all_acc", 32'(dut.acc_q), 32'd0);
    check("clr_all_valid", 32'(product_valid), 32'd0);
    check("clr_all_cnt", 32'(cnt_zero), 32'd0);

    // load wins over shift on My
    mul("m7x9", 16'd7, 9'd9, 25'h000003F, 1'b0, 1'b0);
    Y_in = 9'h155;
    step(6'b011000);
    check("ldsh_my", 32'(product[8:0]), 32'h155);
    check("ldsh_valid", 32'(product_valid), 32'd0);
    check("ldsh_cnt", 32'(cnt_zero), 32'd0);

    // zero operands, back to back without reset
    mul("mx0", 16'h0000, 9'h1FF, 25'h0, 1'b0, 1'b0);
    mul("my0", 16'h1234, 9'h000, 25'h0, 1'b0, 1'b0);
    mul("mbb", 16'hABCD, 9'h002, 25'h001579A, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
